// File: rtl/rr_arbiter_rts_dcts_pkg.sv
// Shared router constants, port indices and arbiter state encoding.
// Latency and backpressure are not applicable; this file holds declarations only.
package rr_arbiter_rts_dcts_pkg;

    localparam int NUM_PORTS_DEFAULT = 5;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_N     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_W     = 3;
    localparam int PORT_S     = 4;

    typedef logic [$clog2(NUM_PORTS_DEFAULT)-1:0] idx_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } arb_st_e;

    // A hold limit of 0 means unlimited, but the counter still needs one bit.
    function automatic int cnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_rts_dcts_if.sv
// Request, handshake and crossbar-select bundle for one router output port.
// The master side is the arbiter and the slave side is the port environment.
interface rr_arbiter_rts_dcts_if
    import rr_arbiter_rts_dcts_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT
);
    logic [NUM_PORTS-1:0]         req;
    logic                         dcts;
    logic [NUM_PORTS-1:0]         grant;
    logic [NUM_PORTS-1:0]         xbar_sel;
    logic                         rts;
    logic [$clog2(NUM_PORTS)-1:0] served_idx;

    modport master (
        input  req,
        input  dcts,
        output grant,
        output xbar_sel,
        output rts,
        output served_idx
    );

    modport slave (
        output req,
        output dcts,
        input  grant,
        input  xbar_sel,
        input  rts,
        input  served_idx
    );
endinterface

// File: rtl/rr_arbiter_rts_dcts_rr_pick.sv
// Circular first-requester search starting at a given index, optionally skipping one port.
// The search is purely combinational with no latency and no flow control.
module rr_pick #(
    parameter int NUM_PORTS = 5,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     start,
    input  logic                 excl_en,
    input  logic [IDX_W-1:0]     excl,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = (int'(start) + i) % NUM_PORTS;
            if (!found && req[k] && !(excl_en && (IDX_W'(k) == excl))) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_rts_dcts.sv
// Round-robin output arbiter with RTS/DCTS handshake, rotating priority and a hold limit.
// The first grant comes 2 cycles after req; rts=1 with dcts=0 freezes state, rts and hold count.
module rr_arbiter_rts_dcts
    import rr_arbiter_rts_dcts_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT,
    parameter int MAX_HOLD  = 8,
    parameter int CNT_W     = cnt_width(MAX_HOLD)
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_arbiter_rts_dcts_if.master   bus
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_st_e              st, st_nxt;
    logic [IDX_W-1:0]     cur, cur_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic [CNT_W-1:0]     hold_cnt, hold_nxt;
    logic                 rts_q, rts_nxt;

    logic [NUM_PORTS-1:0] cur_oh;
    logic [NUM_PORTS-1:0] xbar_sel;
    logic                 stall;
    logic                 transfer;
    logic                 others_req;
    logic                 hold_ok;
    logic [IDX_W-1:0]     rot_start;
    logic                 idle_found, rot_found;
    logic [IDX_W-1:0]     idle_idx, rot_idx;

    assign cur_oh     = NUM_PORTS'(1) << cur;
    assign stall      = rts_q & ~bus.dcts;
    assign transfer   = (st == ST_SERVE) & rts_q & bus.dcts;
    assign others_req = |(bus.req & ~cur_oh);
    assign rot_start  = (cur == IDX_W'(NUM_PORTS - 1)) ? '0 : cur + IDX_W'(1);
    assign hold_ok    = (MAX_HOLD == 0) || (hold_cnt < CNT_W'(MAX_HOLD)) || !others_req;

    rr_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_idle_pick (
        .req     (bus.req),
        .start   (ptr),
        .excl_en (1'b0),
        .excl    ('0),
        .found   (idle_found),
        .idx     (idle_idx)
    );

    rr_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rot_pick (
        .req     (bus.req),
        .start   (rot_start),
        .excl_en (1'b1),
        .excl    (cur),
        .found   (rot_found),
        .idx     (rot_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            cur      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            rts_q    <= 1'b0;
        end else begin
            st       <= st_nxt;
            cur      <= cur_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            rts_q    <= rts_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        cur_nxt  = cur;
        ptr_nxt  = ptr;
        hold_nxt = hold_cnt;
        rts_nxt  = rts_q;
        if (!stall) begin
            rts_nxt = (st == ST_SERVE) && !(rts_q && bus.dcts);
            if (transfer && (hold_cnt != CNT_W'(MAX_HOLD))) begin
                hold_nxt = hold_cnt + CNT_W'(1);
            end
            case (st)
                ST_IDLE: begin
                    if (idle_found) begin
                        st_nxt  = ST_SERVE;
                        cur_nxt = idle_idx;
                    end
                end
                ST_SERVE: begin
                    // A port change or a drop to idle clears the hold count even on a transfer.
                    if (bus.req[cur] && hold_ok) begin
                        st_nxt = ST_SERVE;
                    end else if (rot_found) begin
                        cur_nxt  = rot_idx;
                        ptr_nxt  = rot_start;
                        hold_nxt = '0;
                    end else if (!bus.req[cur]) begin
                        st_nxt   = ST_IDLE;
                        cur_nxt  = '0;
                        ptr_nxt  = rot_start;
                        hold_nxt = '0;
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    assign xbar_sel       = (st == ST_SERVE) ? cur_oh : '0;
    assign bus.xbar_sel   = xbar_sel;
    assign bus.grant      = xbar_sel & {NUM_PORTS{rts_q & bus.dcts}};
    assign bus.rts        = rts_q;
    assign bus.served_idx = (st == ST_SERVE) ? cur : '0;

endmodule
